// File: rtl/reg_wb_queue.sv
// In-order writeback queue feeding the register file write port, with two
// bypass lookups so decode can see values that are still waiting to be written.
module reg_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              rf_stall,
  output logic              regWr,
  output logic [ADDR_W-1:0] wrReg,
  output logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] qReg1,
  input  logic [ADDR_W-1:0] qReg2,
  output logic              qHit1,
  output logic              qHit2,
  output logic [DATA_W-1:0] qData1,
  output logic [DATA_W-1:0] qData2,
  output logic [ADDR_W-1:0] count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] regs  [DEPTH];
  logic [DATA_W-1:0] datas [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  logic              mem_fire;
  logic              alu_fire;
  logic [ADDR_W-1:0] push_reg;
  logic [DATA_W-1:0] push_data;
  logic              push;

  // Scan oldest to youngest so the youngest matching entry is the one kept.
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] q);
    logic              hit;
    logic [DATA_W-1:0] d;
    logic [PTR_W-1:0]  idx;
    hit = 1'b0;
    d   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((ADDR_W'(i) < count) && (regs[idx] == q) && (q != '0)) begin
        hit = 1'b1;
        d   = datas[idx];
      end
    end
    return {hit, d};
  endfunction

  assign full  = (count == ADDR_W'(DEPTH));
  assign empty = (count == '0);

  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign push_reg  = mem_fire ? mem_reg  : alu_reg;
  assign push_data = mem_fire ? mem_data : alu_data;
  // Writes to r0 are handshaken normally but dropped, since r0 is hardwired.
  assign push      = (mem_fire || alu_fire) && (push_reg != '0);

  assign regWr  = !empty && !rf_stall;
  assign wrReg  = regs[head];
  assign wrData = datas[head];

  always_comb begin
    {qHit1, qData1} = lookup(qReg1);
    {qHit2, qData2} = lookup(qReg2);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + 1'b1;
      if (regWr) head <= head + 1'b1;
      count <= count + ADDR_W'(push) - ADDR_W'(regWr);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      regs[tail]  <= push_reg;
      datas[tail] <= push_data;
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized scoreboard bench for reg_wb_queue: a queue-based pending-list model
// predicts status, readiness and bypass; a monitor checks every register write.
module tb_reg_wb_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_reg;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_reg;
  logic [DATA_W-1:0] alu_data;
  logic              rf_stall;
  logic              regWr;
  logic [ADDR_W-1:0] wrReg;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] qReg1;
  logic [ADDR_W-1:0] qReg2;
  logic              qHit1;
  logic              qHit2;
  logic [DATA_W-1:0] qData1;
  logic [DATA_W-1:0] qData2;
  logic [ADDR_W-1:0] count;
  logic              full;
  logic              empty;

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } entry_t;

  entry_t model[$];
  entry_t exp_q[$];
  int checks = 0;
  int errors = 0;

  reg_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .rf_stall(rf_stall), .regWr(regWr), .wrReg(wrReg), .wrData(wrData),
    .qReg1(qReg1), .qReg2(qReg2), .qHit1(qHit1), .qHit2(qHit2),
    .qData1(qData1), .qData2(qData2), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DATA_W:0] ref_lookup(input logic [ADDR_W-1:0] q);
    if (q == 0) return '0;
    for (int i = model.size() - 1; i >= 0; i--)
      if (model[i].r == q) return {1'b1, model[i].d};
    return '0;
  endfunction

  // Monitor: every write must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (regWr === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", regWr, 1'b0);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        chk("wrReg", wrReg, e.r);
        chk("wrData", wrData, e.d);
      end
    end
  end

  // Reference model: compare status against pending list, then apply this edge.
  always begin
    int n;
    logic mem_acc;
    logic alu_acc;
    entry_t e;
    @(negedge clk);
    #1;
    n = model.size();
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("full", full, n == DEPTH);
    chk("mem_ready", mem_ready, n < DEPTH);
    chk("alu_ready", alu_ready, (n < DEPTH) && !mem_valid);
    chk("regWr", regWr, (n > 0) && !rf_stall);
    chk("bypass1", {qHit1, qData1}, ref_lookup(qReg1));
    chk("bypass2", {qHit2, qData2}, ref_lookup(qReg2));
    if (!reset) begin
      model.delete();
      exp_q.delete();
    end else begin
      if (n > 0 && !rf_stall) void'(model.pop_front());
      mem_acc = mem_valid && (n < DEPTH);
      alu_acc = alu_valid && (n < DEPTH) && !mem_valid;
      if (mem_acc && mem_reg != 0) begin
        e.r = mem_reg; e.d = mem_data;
        model.push_back(e); exp_q.push_back(e);
      end else if (alu_acc && alu_reg != 0) begin
        e.r = alu_reg; e.d = alu_data;
        model.push_back(e); exp_q.push_back(e);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_mem(input logic v, input int r, input logic [DATA_W-1:0] d);
    mem_valid = v; mem_reg = ADDR_W'(r); mem_data = d;
  endtask

  task automatic drive_alu(input logic v, input int r, input logic [DATA_W-1:0] d);
    alu_valid = v; alu_reg = ADDR_W'(r); alu_data = d;
  endtask

  initial begin
    reset = 1'b0; rf_stall = 1'b0; qReg1 = '0; qReg2 = '0;
    drive_mem(0, 0, 0); drive_alu(0, 0, 0);
    step(2);
    reset = 1'b1;
    step(2);

    drive_mem(1, 3, 32'hAAAA0001); step();
    drive_mem(0, 0, 0); drive_alu(1, 4, 32'h00000055); step();
    drive_alu(0, 0, 0); step(3);

    drive_mem(1, 5, 32'h0000_0505); drive_alu(1, 6, 32'h0000_0606); step();
    drive_mem(0, 0, 0); step();
    drive_alu(0, 0, 0); step(3);

    rf_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_mem(1, i, 32'h1000_0000 + 32'(i)); step();
    end
    drive_mem(1, 9, 32'hDEAD_0009); drive_alu(1, 10, 32'hDEAD_000A); step();
    drive_mem(0, 0, 0); drive_alu(0, 0, 0); rf_stall = 1'b0; step(6);
    rf_stall = 1'b1;
    for (int i = 11; i <= 13; i++) begin
      drive_mem(1, i, 32'h2000_0000 + 32'(i)); step();
    end
    drive_mem(0, 0, 0); rf_stall = 1'b0; step(5);

    rf_stall = 1'b1; qReg1 = 5'd7; qReg2 = 5'd0;
    drive_alu(1, 7, 32'h11); step();
    drive_alu(1, 7, 32'h22); step();
    drive_alu(0, 0, 0); qReg2 = 5'd7; step();
    rf_stall = 1'b0; step(3);

    drive_alu(1, 0, 32'hFF); step();
    drive_alu(0, 0, 0); step();
    rf_stall = 1'b1;
    for (int i = 20; i <= 22; i++) begin
      drive_mem(1, i, 32'h3000_0000 + 32'(i)); step();
    end
    drive_mem(0, 0, 0); reset = 1'b0; step();
    reset = 1'b1; rf_stall = 1'b0; step(4);

    repeat (500) begin
      reset    = ($urandom_range(0, 99) != 0);
      rf_stall = ($urandom_range(0, 9) < 3);
      drive_mem($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      drive_alu($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      qReg1 = ADDR_W'($urandom_range(0, 7));
      qReg2 = ADDR_W'($urandom_range(0, 7));
      step();
    end

    reset = 1'b1; rf_stall = 1'b0;
    drive_mem(0, 0, 0); drive_alu(0, 0, 0);
    step(8);
    chk("drain_left", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
